// File: rtl/ram_window_reader.sv
// Read-side master for the byte-packed feature RAM: fetches a CHANNELS x ROWS x COLS
// window word by word and streams it out one byte per cycle with channel/row/col tags.
module ram_window_reader #(
    parameter int unsigned BAND     = 64,
    parameter int unsigned DEPTH    = 1024,
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned ROWS     = 3,
    parameter int unsigned COLS     = 18,
    localparam int unsigned AW  = $clog2(DEPTH),
    localparam int unsigned CHW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    localparam int unsigned RW  = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int unsigned CW  = (COLS > 1) ? $clog2(COLS) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [AW-1:0]   base_addr,
    output logic            ram_rd,
    output logic [AW-1:0]   ram_addr,
    input  logic [BAND-1:0] ram_data,
    input  logic            ram_valid,
    output logic [7:0]      out_byte,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [CHW-1:0]  out_ch,
    output logic [RW-1:0]   out_row,
    output logic [CW-1:0]   out_col,
    output logic            out_last,
    output logic            busy,
    output logic            done
);

    localparam int unsigned LANES = BAND / 8;
    localparam int unsigned LW    = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int unsigned N     = CHANNELS * ROWS * COLS;
    localparam int unsigned KW    = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_EMIT, S_DONE} state_t;

    state_t          state;
    logic [BAND-1:0] word_buf;
    logic [KW-1:0]   k;
    logic [LW-1:0]   lane;

    logic [KW-1:0]   k_inc;
    logic [LW-1:0]   lane_inc;
    logic [AW-1:0]   addr_inc;
    logic [CW-1:0]   col_n;
    logic [RW-1:0]   row_n;
    logic [CHW-1:0]  ch_n;
    logic            k_end;
    logic            lane_end;

    // Next-index helpers: byte counter, lane, wrapped word address and tag roll-over.
    always_comb begin
        k_inc    = k + KW'(1);
        lane_inc = lane + LW'(1);
        k_end    = (k == KW'(N - 1));
        lane_end = (lane == LW'(LANES - 1));
        addr_inc = (ram_addr == AW'(DEPTH - 1)) ? '0 : ram_addr + AW'(1);
        col_n    = out_col + CW'(1);
        row_n    = out_row;
        ch_n     = out_ch;
        if (out_col == CW'(COLS - 1)) begin
            col_n = '0;
            if (out_row == RW'(ROWS - 1)) begin
                row_n = '0;
                ch_n  = out_ch + CHW'(1);
            end else begin
                row_n = out_row + RW'(1);
            end
        end
    end

    // Window walker; every output is a register updated alongside the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            word_buf  <= '0;
            k         <= '0;
            lane      <= '0;
            ram_rd    <= 1'b0;
            ram_addr  <= '0;
            out_byte  <= '0;
            out_valid <= 1'b0;
            out_ch    <= '0;
            out_row   <= '0;
            out_col   <= '0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        k        <= '0;
                        lane     <= '0;
                        out_ch   <= '0;
                        out_row  <= '0;
                        out_col  <= '0;
                        ram_addr <= base_addr;
                        ram_rd   <= 1'b1;
                        busy     <= 1'b1;
                        state    <= S_REQ;
                    end
                end
                S_REQ: begin
                    ram_rd <= 1'b0;
                    state  <= S_WAIT;
                end
                S_WAIT: begin
                    if (ram_valid) begin
                        word_buf  <= ram_data;
                        out_byte  <= ram_data[7:0];
                        out_valid <= 1'b1;
                        out_last  <= k_end;
                        state     <= S_EMIT;
                    end
                end
                S_EMIT: begin
                    if (out_ready) begin
                        if (k_end) begin
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            done      <= 1'b1;
                            state     <= S_DONE;
                        end else begin
                            k       <= k_inc;
                            out_col <= col_n;
                            out_row <= row_n;
                            out_ch  <= ch_n;
                            if (lane_end) begin
                                lane      <= '0;
                                ram_addr  <= addr_inc;
                                ram_rd    <= 1'b1;
                                out_valid <= 1'b0;
                                out_last  <= 1'b0;
                                state     <= S_REQ;
                            end else begin
                                lane     <= lane_inc;
                                out_byte <= 8'(word_buf >> {lane_inc, 3'b000});
                                out_last <= (k_inc == KW'(N - 1));
                            end
                        end
                    end
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_window_reader.sv
// Bench for ram_window_reader: two instances (COLS=18 and COLS=33) driven from a
// scenario table and compared against a byte-index model of the window.
module tb_ram_window_reader;

    localparam int N0 = 216;
    localparam int N1 = 396;
    localparam int BUDGET = 5000;

    logic        clk = 1'b0;
    logic        rst;
    logic        start [2];
    logic [9:0]  base  [2];
    logic        rdy   [2];
    logic        rd    [2];
    logic [9:0]  addr  [2];
    logic [63:0] rdata [2];
    logic        rvalid[2];
    logic [7:0]  ob    [2];
    logic        ov    [2];
    logic        ol    [2];
    logic        bsy   [2];
    logic        dn    [2];
    logic [1:0]  och   [2];
    logic [1:0]  orow  [2];
    logic [4:0]  ocol0;
    logic [5:0]  ocol1;

    logic [63:0] mem [2][1024];
    int          lat [2];
    int          cnt [2];
    logic [9:0]  pa  [2];
    logic        spur[2];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ram_window_reader u_dut0 (
        .clk(clk), .rst(rst), .start(start[0]), .base_addr(base[0]),
        .ram_rd(rd[0]), .ram_addr(addr[0]), .ram_data(rdata[0]), .ram_valid(rvalid[0]),
        .out_byte(ob[0]), .out_valid(ov[0]), .out_ready(rdy[0]),
        .out_ch(och[0]), .out_row(orow[0]), .out_col(ocol0),
        .out_last(ol[0]), .busy(bsy[0]), .done(dn[0])
    );

    ram_window_reader #(.COLS(33)) u_dut1 (
        .clk(clk), .rst(rst), .start(start[1]), .base_addr(base[1]),
        .ram_rd(rd[1]), .ram_addr(addr[1]), .ram_data(rdata[1]), .ram_valid(rvalid[1]),
        .out_byte(ob[1]), .out_valid(ov[1]), .out_ready(rdy[1]),
        .out_ch(och[1]), .out_row(orow[1]), .out_col(ocol1),
        .out_last(ol[1]), .busy(bsy[1]), .done(dn[1])
    );

    // RAM model: returns the addressed word lat cycles after rd; spur injects a stray valid.
    always @(posedge clk) begin
        for (int g = 0; g < 2; g++) begin
            rvalid[g] <= spur[g];
            if (spur[g]) rdata[g] <= '1;
            if (rst) begin
                cnt[g] <= 0;
            end else if (rd[g]) begin
                pa[g]  <= addr[g];
                cnt[g] <= lat[g] - 1;
                if (lat[g] == 1) begin
                    rvalid[g] <= 1'b1;
                    rdata[g]  <= mem[g][addr[g]];
                end
            end else if (cnt[g] != 0) begin
                cnt[g] <= cnt[g] - 1;
                if (cnt[g] == 1) begin
                    rvalid[g] <= 1'b1;
                    rdata[g]  <= mem[g][pa[g]];
                end
            end
        end
    end

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int col_of(input int d);
        return (d == 0) ? int'(ocol0) : int'(ocol1);
    endfunction

    task automatic check_zero(input string tag, input int d);
        chk({tag, " ram_rd"},    longint'(rd[d]),   0);
        chk({tag, " ram_addr"},  longint'(addr[d]), 0);
        chk({tag, " out_byte"},  longint'(ob[d]),   0);
        chk({tag, " out_valid"}, longint'(ov[d]),   0);
        chk({tag, " out_last"},  longint'(ol[d]),   0);
        chk({tag, " busy"},      longint'(bsy[d]),  0);
        chk({tag, " done"},      longint'(dn[d]),   0);
        chk({tag, " tags"}, longint'(och[d]) + longint'(orow[d]) + longint'(col_of(d)), 0);
    endtask

    typedef struct {
        int d;
        int base;
        bit throttle;
        int lat;
        bit spur;
        bit mid;
        bit col_fill;
        int exp_bytes;
        int exp_reads;
        int exp_last_addr;
    } vec_t;

    vec_t tbl[6];

    task automatic run_row(input int r);
        vec_t v;
        int d, n, cols, idx, reads, last_addr, dones, lasts, first_valid, done_cyc;
        bit prev_stall, prev_rd, fin;
        logic [7:0] pb, eb;
        int pch, prow, pcol, plast, sch, srow, scol;
        logic [63:0] w;
        string t;
        v = tbl[r];
        d = v.d;
        n = (d == 0) ? N0 : N1;
        cols = (d == 0) ? 18 : 33;
        t = $sformatf("row%0d", r);
        for (int i = 0; i < 1024; i++) mem[d][i] = {$urandom, $urandom};
        if (v.col_fill) begin
            for (int k = 0; k < n; k++) begin
                w = mem[d][(v.base + k / 8) % 1024];
                w[(k % 8) * 8 +: 8] = 8'(k % cols);
                mem[d][(v.base + k / 8) % 1024] = w;
            end
        end
        lat[d] = v.lat;
        idx = 0; reads = 0; last_addr = -1; dones = 0; lasts = 0;
        first_valid = -1; done_cyc = -1; prev_stall = 0; prev_rd = 0; fin = 0;
        pb = 0; pch = 0; prow = 0; pcol = 0; plast = 0;
        @(negedge clk);
        base[d] = 10'(v.base);
        start[d] = 1'b1;
        rdy[d] = 1'b1;
        for (int cyc = 1; cyc <= BUDGET && !fin; cyc++) begin
            @(negedge clk);
            start[d] = v.mid && (cyc == 20);
            if (v.mid && cyc == 20) base[d] = 10'd0;
            rdy[d] = v.throttle ? 1'($urandom_range(0, 1)) : 1'b1;
            spur[d] = 1'b0;
            sch = int'(och[d]); srow = int'(orow[d]); scol = col_of(d);
            chk({t, " busy"}, longint'(bsy[d]), 1);
            if (rd[d]) begin
                chk({t, " rd_addr"}, longint'(addr[d]), longint'((v.base + reads) % 1024));
                chk({t, " rd_single"}, longint'(prev_rd), 0);
                last_addr = int'(addr[d]);
                reads++;
            end
            prev_rd = rd[d];
            if (prev_stall) begin
                chk({t, " stall_valid"}, longint'(ov[d]), 1);
                chk({t, " stall_byte"}, longint'(ob[d]), longint'(pb));
                chk({t, " stall_tags"}, longint'(sch * 4096 + srow * 64 + scol),
                    longint'(pch * 4096 + prow * 64 + pcol));
                chk({t, " stall_last"}, longint'(ol[d]), longint'(plast));
            end
            if (ov[d]) begin
                if (first_valid < 0) first_valid = cyc;
                if (idx >= n) begin
                    chk({t, " extra_byte"}, longint'(idx), longint'(n - 1));
                end else if (!prev_stall) begin
                    w = mem[d][(v.base + idx / 8) % 1024];
                    eb = w[(idx % 8) * 8 +: 8];
                    chk({t, " byte"}, longint'(ob[d]), longint'(eb));
                    chk({t, " ch"}, longint'(sch), longint'(idx / (3 * cols)));
                    chk({t, " row"}, longint'(srow), longint'((idx / cols) % 3));
                    chk({t, " col"}, longint'(scol), longint'(idx % cols));
                    chk({t, " last"}, longint'(ol[d]), longint'(idx == n - 1));
                end
                if (rdy[d]) begin
                    if (ol[d]) lasts++;
                    idx++;
                end
                prev_stall = !rdy[d];
                pb = ob[d]; pch = sch; prow = srow; pcol = scol; plast = int'(ol[d]);
                if (v.spur && (cyc % 5 == 0)) spur[d] = 1'b1;
            end else begin
                prev_stall = 0;
            end
            if (dn[d]) begin
                dones++;
                done_cyc = cyc;
                fin = 1;
            end
        end
        start[d] = 1'b0;
        spur[d] = 1'b0;
        if (!fin) chk({t, " timeout"}, 0, 1);
        chk({t, " bytes"}, longint'(idx), longint'(v.exp_bytes));
        chk({t, " reads"}, longint'(reads), longint'(v.exp_reads));
        chk({t, " last_addr"}, longint'(last_addr), longint'(v.exp_last_addr));
        chk({t, " done_pulses"}, longint'(dones), 1);
        chk({t, " last_count"}, longint'(lasts), 1);
        chk({t, " first_valid_cyc"}, longint'(first_valid), longint'(2 + v.lat));
        if (!v.throttle && d == 0)
            chk({t, " done_cyc"}, longint'(done_cyc), longint'(1 + (N0 / 8) * (1 + v.lat + 8)));
        @(negedge clk);
        chk({t, " idle_busy"}, longint'(bsy[d]), 0);
        chk({t, " idle_done"}, longint'(dn[d]), 0);
        chk({t, " idle_valid"}, longint'(ov[d]), 0);
    endtask

    initial begin
        //         d  base  thr lat spur mid fill bytes reads last_addr
        tbl[0] = '{0, 0,    0,  1,  0,   0,  1,   N0,  27,   26};
        tbl[1] = '{1, 0,    0,  1,  0,   0,  1,   N1,  50,   49};
        tbl[2] = '{0, 0,    1,  1,  0,   0,  1,   N0,  27,   26};
        tbl[3] = '{0, 100,  0,  3,  1,   0,  0,   N0,  27,   126};
        tbl[4] = '{0, 1022, 1,  1,  0,   1,  0,   N0,  27,   24};
        tbl[5] = '{1, 1000, 1,  2,  1,   0,  0,   N1,  50,   25};

        rst = 1'b1;
        for (int g = 0; g < 2; g++) begin
            start[g] = 1'b0; base[g] = '0; rdy[g] = 1'b1; lat[g] = 1; spur[g] = 1'b0;
        end
        repeat (2) @(negedge clk);
        check_zero("reset0", 0);
        check_zero("reset1", 1);
        rst = 1'b0;
        @(negedge clk);

        // Reset mid-EMIT: outputs clear asynchronously and the reader returns idle.
        for (int i = 0; i < 1024; i++) mem[0][i] = {$urandom, $urandom};
        base[0] = 10'd5;
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        for (int i = 0; i < 50 && !ov[0]; i++) @(negedge clk);
        chk("pre_reset_valid", longint'(ov[0]), 1);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check_zero("async_reset0", 0);
        check_zero("async_reset1", 1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_reset_busy", longint'(bsy[0]), 0);

        for (int r = 0; r < 6; r++) run_row(r);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ram_window_reader.md
# ram_window_reader

Read-side master for the byte-packed feature RAM. On `start` it walks a CHANNELS×ROWS×COLS window stored little-endian, eight bytes per BAND-bit word, from `base_addr` upward. It issues single-cycle `rd` requests to the RAM, captures each returned word, and streams the bytes out one per cycle under a valid/ready handshake, tagged with channel, row and column indices. It sits between the feature RAM and the convolution datapath.

## Interface
- BAND, 64, RAM word width in bits; must be a multiple of 8; LANES = BAND/8.
- DEPTH, 1024, RAM depth in words; AW = $clog2(DEPTH).
- CHANNELS, 4, channels in the window.
- ROWS, 3, rows per channel.
- COLS, 18, bytes per row.
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin a window read; sampled only in IDLE.
- base_addr  in  AW  word address of byte 0.
- ram_rd  out  1  read request to RAM.
- ram_addr  out  AW  RAM word address.
- ram_data  in  BAND  RAM read data.
- ram_valid  in  1  RAM read-data valid; RAM registers data one cycle after `rd`.
- out_byte  out  8  current byte.
- out_valid  out  1  `out_byte` and tags are valid.
- out_ready  in  1  consumer accepts the byte.
- out_ch / out_row / out_col  out  max(1,$clog2(CHANNELS/ROWS/COLS))  tags of `out_byte`.
- out_last  out  1  current byte is the final byte of the window.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse after the last byte is accepted.

## Operation
- The linear byte index is k = c·ROWS·COLS + r·COLS + col. The byte is read from word base_addr + k/LANES, bits [(k%LANES)·8 +: 8]. N = CHANNELS·ROWS·COLS. The window spans ceil(N/LANES) words.
- The state machine has five states: IDLE, REQ, WAIT, EMIT, DONE.
- IDLE:
  - `start`=1 latches `base_addr`, clears k, word address and lane, then goes to REQ.
  - `start` in any other state is ignored.
- REQ:
  - `ram_rd`=1 and `ram_addr` = current word for exactly one cycle.
  - Always goes to WAIT.
- WAIT:
  - Holds until `ram_valid`=1.
  - On that edge it captures `ram_data` into the word buffer and goes to EMIT.
  - `ram_valid` is ignored in every other state.
- EMIT:
  - `out_valid`=1. `out_byte` is the buffer lane. Tags are c/r/col.
  - On `out_valid & out_ready`:
    - k increments; col increments and wraps at COLS into row; row wraps at ROWS into channel.
    - If k was N−1, go to DONE.
    - Otherwise, if the lane was LANES−1, the lane resets to 0, the word address increments, and the state goes to REQ.
    - Otherwise the lane increments and the state stays in EMIT.
  - While `out_ready`=0, byte, tags and `out_last` are held stable.
- DONE: `done`=1 for one cycle, then IDLE.
- A partial last word (N%LANES≠0) emits only N%LANES bytes; the unused upper lanes are never output.
- Address arithmetic is AW bits wide and wraps modulo DEPTH.
- `out_last` = (k == N−1) & `out_valid`.

## Timing
- Reset (async, any state) forces:
  - state = IDLE;
  - ram_rd, out_valid, out_last, busy, done = 0;
  - ram_addr, out_byte, out_ch, out_row, out_col = 0.
- All outputs are registered or decoded from registered state; no combinational path runs from `out_ready` or `ram_valid` to any output.
- `start` sampled at edge E0:
  - `ram_rd` is high in cycle E0–E1.
  - The RAM returns `ram_valid` in cycle E1–E2.
  - The word is captured at E2.
  - The first `out_valid` is high from E2.
- Per full word with `out_ready` held high: 2 request/wait cycles + LANES emit cycles.
- Reset asserted mid-window abandons the transfer. No `done` pulse is produced. The next `start` restarts from k=0.

## Test plan
- Reset during EMIT -> all outputs read 0 immediately (asynchronous). After release, `busy`=0 and the next `start` produces col=0, row=0, ch=0 first.
- Default parameters, RAM preloaded with byte value = col index, base_addr=0, `out_ready`=1:
  - 216 bytes come out, forming the sequence 0..17 repeated 12 times;
  - `out_last` is set only on byte 216;
  - `done` pulses once;
  - 27 `ram_rd` pulses are issued at addresses 0..26.
- COLS=33 with the same preload style: 396 bytes; 50 reads; the last word (addr 49) emits only 4 bytes; tags end at ch=3, row=2, col=32.
- Random `out_ready` throttling (about 50% low): the byte stream is identical to the previous run, and byte/tags are stable on every stalled cycle.
- RAM model delaying `ram_valid` by 3 cycles: the reader stays in WAIT with `ram_rd`=0 and captures the correct word. A spurious `ram_valid` pulse during EMIT is ignored.
- `start` asserted while busy, plus base_addr=DEPTH−2: the mid-run `start` has no effect, and the addresses wrap 1022, 1023, 0, ….
